traffic_intersection_ctrl: RTL and testbench
============================================

// Module: traffic_intersection_ctrl
// PURPOSE
//   Two-approach (NS/EW) intersection controller, parametrised successor of the single-signal
//   R/G/Y sequencer. Adds all-red clearance, latched pedestrian walk phase, flashing-yellow
//   maintenance mode and a tick enable for prescaled timing. Sits between the timebase
//   prescaler and the lamp drivers.
// PARAMETERS
//   CNT_W        4  dwell counter width; every *_TICKS value must be in 1..2**CNT_W
//   GREEN_TICKS  6  ticks per green phase (each approach)
//   YELLOW_TICKS 4  ticks per yellow phase (each approach)
//   CLR_TICKS    2  ticks per all-red clearance
//   PED_TICKS    5  ticks per pedestrian walk phase
//   FLASH_TICKS  2  ticks per half-period of the flash blink
// PORTS
//   clk         in   1  rising-edge clock
//   reset       in   1  synchronous, active-high reset
//   tick        in   1  timing enable; dwell/blink counters advance only when high
//   ped_req     in   1  pedestrian request; sampled every clk, any width >= 1 cycle
//   flash_mode  in   1  level; high = maintenance flashing-yellow mode
//   ns_light    out  3  NS lamps {R,Y,G}: 100 red, 010 yellow, 001 green, 000 dark
//   ew_light    out  3  EW lamps, same encoding
//   ped_walk    out  1  walk signal, high only in PED state
//   ped_pending out  1  request latched, not yet served
//   phase       out  3  0 CLR, 1 NS_G, 2 NS_Y, 3 EW_G, 4 EW_Y, 5 PED, 6 FLASH
// BEHAVIOUR
//   - Moore FSM. Outputs decode combinationally from registered state: a lamp changes
//     in the same cycle its state is entered. No extra output-lag cycle.
//   - Reset: state CLR, next_dir=NS, cnt=0, ped_pending=0, blink=0.
//     Outputs: ns_light=ew_light=100, ped_walk=0, phase=0.
//   - Dwell: cnt clears on every state entry and increments on tick.
//     A state with N ticks exits on the tick where cnt==N-1, so it lasts exactly N ticks.
//   - Sequence:
//     CLR -> PED if ped_pending, else NS_G or EW_G per next_dir.
//     NS_G -> NS_Y -> CLR, which sets next_dir=EW.
//     EW_G -> EW_Y -> CLR, which sets next_dir=NS.
//     PED -> NS_G or EW_G per next_dir. PED goes straight to green with no second CLR.
//   - Lamps:
//     NS_G: NS 001, EW 100.   NS_Y: NS 010, EW 100.
//     EW_G: NS 100, EW 001.   EW_Y: NS 100, EW 010.
//     CLR and PED: both 100.
//   - Pedestrian:
//     ped_pending sets on any cycle with ped_req=1 outside PED.
//     It clears on the cycle PED is entered. ped_req in PED, or on the entry cycle, is ignored.
//     Requests made during FLASH are held.
//   - Flash:
//     flash_mode=1 forces FLASH on the next clk from any state, regardless of tick.
//     On entry blink=1. blink toggles every FLASH_TICKS ticks.
//     Both lights = blink ? 010 : 000.
//     flash_mode=0 in FLASH -> CLR with next_dir=NS and cnt=0.
//     flash_mode has priority over all dwell exits.
//   - tick=0 freezes cnt and blink. flash_mode, ped_req and reset still act every cycle.
//   - Reset asserted mid-phase returns to the reset state on the next edge and drops any
//     pending request.
// TESTING  (defaults, tick tied high; cycle 0 = first edge after reset release)
//   - Free run: CLR 0-1, NS_G 2-7, NS_Y 8-11, CLR 12-13, EW_G 14-19, EW_Y 20-23,
//     CLR 24-25, NS_G at 26. Lamp codes per the table above.
//   - ped_req pulse at cycle 5 -> ped_pending=1 from cycle 6.
//     PED 14-18 with ped_walk=1 and both lamps 100. ped_pending=0 from 14. EW_G 19-24.
//   - ped_req held 3-16 -> exactly one PED phase, 14-18. A second request raised at 19
//     latches and is served after the next CLR, at 31.
//   - flash_mode=1 at cycle 9 (NS_Y) -> FLASH from 10. Lamps 010,010 for 10-11,
//     000,000 for 12-13, then repeating. flash_mode=0 at 20 -> CLR 21-22, NS_G at 23.
//   - tick high every 2nd cycle -> all dwell durations double in clk cycles.
//     flash entry still occurs 1 clk after flash_mode rises.
//   - reset at cycle 16 (EW_G, ped pending) -> at cycle 17: CLR, ped_pending=0,
//     both lamps 100; sequence restarts as in free run.

Source files
------------

// File: rtl/traffic_intersection_ctrl.sv
// Two-approach (NS/EW) intersection controller: green/yellow per approach, all-red
// clearance, latched pedestrian walk phase and flashing-yellow maintenance mode.
module traffic_intersection_ctrl #(
    parameter int CNT_W        = 4,
    parameter int GREEN_TICKS  = 6,
    parameter int YELLOW_TICKS = 4,
    parameter int CLR_TICKS    = 2,
    parameter int PED_TICKS    = 5,
    parameter int FLASH_TICKS  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       ped_req,
    input  logic       flash_mode,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       ped_walk,
    output logic       ped_pending,
    output logic [2:0] phase
);

    localparam logic [2:0] S_CLR   = 3'd0;
    localparam logic [2:0] S_NS_G  = 3'd1;
    localparam logic [2:0] S_NS_Y  = 3'd2;
    localparam logic [2:0] S_EW_G  = 3'd3;
    localparam logic [2:0] S_EW_Y  = 3'd4;
    localparam logic [2:0] S_PED   = 3'd5;
    localparam logic [2:0] S_FLASH = 3'd6;

    localparam logic [2:0] LAMP_R    = 3'b100;
    localparam logic [2:0] LAMP_Y    = 3'b010;
    localparam logic [2:0] LAMP_G    = 3'b001;
    localparam logic [2:0] LAMP_DARK = 3'b000;

    // Last count value of each dwell; a state exits on the tick where cnt reaches it.
    localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] CLR_LAST    = CNT_W'(CLR_TICKS - 1);
    localparam logic [CNT_W-1:0] PED_LAST    = CNT_W'(PED_TICKS - 1);
    localparam logic [CNT_W-1:0] FLASH_LAST  = CNT_W'(FLASH_TICKS - 1);

    logic [2:0]       state;
    logic [2:0]       next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] dwell_last;
    logic             dwell_done;
    logic             next_dir_ew;
    logic             blink;

    always_comb begin
        // NOTE: every variable assigned in a combinational block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        dwell_last = CLR_LAST;
        case (state)
            S_NS_G, S_EW_G: dwell_last = GREEN_LAST;
            S_NS_Y, S_EW_Y: dwell_last = YELLOW_LAST;
            S_PED:          dwell_last = PED_LAST;
            S_FLASH:        dwell_last = FLASH_LAST;
            default:        dwell_last = CLR_LAST;
        endcase
    end

    assign dwell_done = tick && (cnt == dwell_last);

    always_comb begin
        next_state = state;
        if (flash_mode) begin
            next_state = S_FLASH;
        end else begin
            case (state)
                S_CLR:
                    if (dwell_done) begin
                        if (ped_pending)      next_state = S_PED;
                        else if (next_dir_ew) next_state = S_EW_G;
                        else                  next_state = S_NS_G;
                    end
                S_NS_G:  if (dwell_done) next_state = S_NS_Y;
                S_NS_Y:  if (dwell_done) next_state = S_CLR;
                S_EW_G:  if (dwell_done) next_state = S_EW_Y;
                S_EW_Y:  if (dwell_done) next_state = S_CLR;
                S_PED:   if (dwell_done) next_state = next_dir_ew ? S_EW_G : S_NS_G;
                S_FLASH: next_state = S_CLR;
                default: next_state = S_CLR;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_CLR;
            cnt         <= '0;
            next_dir_ew <= 1'b0;
            ped_pending <= 1'b0;
            blink       <= 1'b0;
        end else begin
            state <= next_state;

            // In FLASH the dwell counter doubles as the blink half-period counter.
            if (next_state != state)
                cnt <= '0;
            else if (tick)
                cnt <= dwell_done ? '0 : cnt + 1'b1;

            if (next_state != S_FLASH)
                blink <= 1'b0;
            else if (state != S_FLASH)
                blink <= 1'b1;
            else if (dwell_done)
                blink <= ~blink;

            if (next_state == S_CLR) begin
                if (state == S_NS_Y)
                    next_dir_ew <= 1'b1;
                else if (state == S_EW_Y || state == S_FLASH)
                    next_dir_ew <= 1'b0;
            end

            // Entering PED serves the request; requests seen inside PED are dropped.
            if (next_state == S_PED && state != S_PED)
                ped_pending <= 1'b0;
            else if (state != S_PED && ped_req)
                ped_pending <= 1'b1;
        end
    end

    always_comb begin
        ns_light = LAMP_R;
        ew_light = LAMP_R;
        case (state)
            S_NS_G:  ns_light = LAMP_G;
            S_NS_Y:  ns_light = LAMP_Y;
            S_EW_G:  ew_light = LAMP_G;
            S_EW_Y:  ew_light = LAMP_Y;
            S_FLASH: begin
                ns_light = blink ? LAMP_Y : LAMP_DARK;
                ew_light = blink ? LAMP_Y : LAMP_DARK;
            end
            default: begin
                ns_light = LAMP_R;
                ew_light = LAMP_R;
            end
        endcase
    end

    assign ped_walk = (state == S_PED);
    assign phase    = state;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Scoreboard bench for traffic_intersection_ctrl: a countdown-based phase model
// queues expected outputs per clock edge; a monitor compares on the falling edge.
module tb_traffic_intersection_ctrl;

    localparam int GREEN_T  = 6;
    localparam int YELLOW_T = 4;
    localparam int CLR_T    = 2;
    localparam int PED_T    = 5;
    localparam int FLASH_T  = 2;

    localparam int P_CLR = 0, P_NS_G = 1, P_NS_Y = 2, P_EW_G = 3,
                   P_EW_Y = 4, P_PED = 5, P_FLASH = 6;

    typedef struct packed {
        logic [2:0] phase;
        logic [2:0] ns;
        logic [2:0] ew;
        logic       walk;
        logic       pend;
    } obs_t;

    typedef struct {
        obs_t  exp;
        int    seg;
        int    cyc;
    } entry_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b1;
    logic       ped_req = 1'b0;
    logic       flash_mode = 1'b0;
    logic [2:0] ns_light, ew_light, phase;
    logic       ped_walk, ped_pending;

    entry_t q[$];
    int checks = 0;
    int errors = 0;
    int seg_id = 0;
    int cyc_id = 0;

    // Reference model: phase plus ticks remaining in it.
    int m_phase = P_CLR;
    int m_left  = CLR_T;
    bit m_go_ns = 1'b1;
    bit m_pend  = 1'b0;
    bit m_blink = 1'b0;

    traffic_intersection_ctrl #(
        .CNT_W(4), .GREEN_TICKS(GREEN_T), .YELLOW_TICKS(YELLOW_T),
        .CLR_TICKS(CLR_T), .PED_TICKS(PED_T), .FLASH_TICKS(FLASH_T)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick), .ped_req(ped_req),
        .flash_mode(flash_mode), .ns_light(ns_light), .ew_light(ew_light),
        .ped_walk(ped_walk), .ped_pending(ped_pending), .phase(phase)
    );

    always #5 clk = ~clk;

    function automatic int duration(int p);
        case (p)
            P_NS_G, P_EW_G: return GREEN_T;
            P_NS_Y, P_EW_Y: return YELLOW_T;
            P_PED:          return PED_T;
            P_FLASH:        return FLASH_T;
            default:        return CLR_T;
        endcase
    endfunction

    task automatic model_step(bit rst, bit tk, bit pr, bit fm);
        int old;
        if (rst) begin
            m_phase = P_CLR; m_left = CLR_T; m_go_ns = 1'b1;
            m_pend = 1'b0; m_blink = 1'b0;
            return;
        end
        old = m_phase;
        if (fm) begin
            if (old != P_FLASH) begin
                m_phase = P_FLASH; m_left = FLASH_T; m_blink = 1'b1;
            end else if (tk) begin
                m_left--;
                if (m_left == 0) begin
                    m_blink = !m_blink;
                    m_left = FLASH_T;
                end
            end
        end else if (old == P_FLASH) begin
            m_phase = P_CLR; m_left = CLR_T; m_go_ns = 1'b1;
        end else if (tk) begin
            m_left--;
            if (m_left == 0) begin
                case (old)
                    P_CLR:  m_phase = m_pend ? P_PED : (m_go_ns ? P_NS_G : P_EW_G);
                    P_NS_G: m_phase = P_NS_Y;
                    P_NS_Y: begin m_phase = P_CLR; m_go_ns = 1'b0; end
                    P_EW_G: m_phase = P_EW_Y;
                    P_EW_Y: begin m_phase = P_CLR; m_go_ns = 1'b1; end
                    P_PED:  m_phase = m_go_ns ? P_NS_G : P_EW_G;
                    default: m_phase = P_CLR;
                endcase
                m_left = duration(m_phase);
            end
        end
        if (m_phase == P_PED && old != P_PED) m_pend = 1'b0;
        else if (old != P_PED && pr)          m_pend = 1'b1;
    endtask

    function automatic obs_t model_obs();
        obs_t o;
        o.phase = 3'(m_phase);
        o.ns    = 3'b100;
        o.ew    = 3'b100;
        o.walk  = (m_phase == P_PED);
        o.pend  = m_pend;
        case (m_phase)
            P_NS_G:  o.ns = 3'b001;
            P_NS_Y:  o.ns = 3'b010;
            P_EW_G:  o.ew = 3'b001;
            P_EW_Y:  o.ew = 3'b010;
            P_FLASH: begin
                o.ns = m_blink ? 3'b010 : 3'b000;
                o.ew = m_blink ? 3'b010 : 3'b000;
            end
            default: ;
        endcase
        return o;
    endfunction

    // Drive inputs for the coming edge, step the model at that edge, queue expectation.
    task automatic run_cycle(bit rst, bit tk, bit pr, bit fm);
        entry_t e;
        reset = rst; tick = tk; ped_req = pr; flash_mode = fm;
        @(posedge clk);
        model_step(rst, tk, pr, fm);
        e.exp = model_obs();
        e.seg = seg_id;
        e.cyc = cyc_id;
        q.push_back(e);
        #1;
    endtask

    task automatic check(string name, int seg, int cyc, obs_t act, obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s seg=%0d cyc=%0d got phase=%0d ns=%b ew=%b walk=%b pend=%b want phase=%0d ns=%b ew=%b walk=%b pend=%b",
                     name, seg, cyc, act.phase, act.ns, act.ew, act.walk, act.pend,
                     exp.phase, exp.ns, exp.ew, exp.walk, exp.pend);
        end
    endtask

    initial begin : monitor
        entry_t e;
        obs_t   act;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                act = '{phase, ns_light, ew_light, ped_walk, ped_pending};
                check("outputs", e.seg, e.cyc, act, e.exp);
            end
        end
    end

    // Each segment starts from reset; cycle 0 is the state held after the last reset edge.
    task automatic start_segment(int id);
        seg_id = id;
        cyc_id = -2;
        run_cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cyc_id = -1;
        run_cycle(1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin : driver
        bit fm_level;
        start_segment(1);
        for (int c = 0; c < 30; c++) begin
            cyc_id = c; run_cycle(1'b0, 1'b1, 1'b0, 1'b0);
        end
        start_segment(2);
        for (int c = 0; c < 30; c++) begin
            cyc_id = c; run_cycle(1'b0, 1'b1, c == 5, 1'b0);
        end
        start_segment(3);
        for (int c = 0; c < 40; c++) begin
            cyc_id = c; run_cycle(1'b0, 1'b1, (c >= 3 && c <= 16) || c == 19, 1'b0);
        end
        start_segment(4);
        for (int c = 0; c < 32; c++) begin
            cyc_id = c; run_cycle(1'b0, 1'b1, 1'b0, c >= 9 && c <= 19);
        end
        start_segment(5);
        for (int c = 0; c < 80; c++) begin
            cyc_id = c; run_cycle(1'b0, c % 2 == 1, c == 7, c >= 50 && c <= 62);
        end
        start_segment(6);
        for (int c = 0; c < 40; c++) begin
            cyc_id = c; run_cycle(c == 16, 1'b1, c == 15, 1'b0);
        end
        start_segment(7);
        fm_level = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            cyc_id = c;
            if ($urandom_range(0, 59) == 0) fm_level = !fm_level;
            run_cycle($urandom_range(0, 499) == 0, $urandom_range(0, 3) != 0,
                      $urandom_range(0, 7) == 0, fm_level);
        end
        reset = 1'b0; tick = 1'b0; ped_req = 1'b0; flash_mode = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d entries left want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
